pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register that replaces fixed 32-bit load-enable registers between CPU pipeline stages. It carries a WIDTH-bit payload with a valid/ready handshake, a two-entry skid buffer so the upstream ready is fully registered, and a synchronous flush for branch and exception squashing. One instance sits at each stage boundary: IF/ID, ID/EX, EX/MEM, MEM/WB.

## Interface
- WIDTH, 32: payload width in bits (1..128).
- FLUSH_VAL, {WIDTH{1'b0}}: value loaded into Q on reset and flush.
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-low reset (asserted when 0).
- in_valid  in  1  upstream presents D.
- in_ready  out  1  stage can accept; registered output.
- D  in  WIDTH  upstream payload.
- flush  in  1  squash all held entries.
- out_valid  out  1  Q holds a valid payload.
- out_ready  in  1  downstream accepts Q.
- Q  out  WIDTH  payload to the next stage; registered output.
- stall_cnt  out  16  cycles with out_valid=1 and out_ready=0. Present only with PIPE_REG_STALL_CNT_EN.

## Operation
- Accept = in_valid & in_ready. Release = out_valid & out_ready.
- Storage: main register drives Q and out_valid; skid register holds one overflow entry.
- States:
  - EMPTY: nothing held.
  - ONE: main full.
  - TWO: main and skid full.
- EMPTY: on accept, main <= D and go to ONE. Otherwise stay; Q holds its last value.
- ONE:
  - Accept and release: main <= D, stay in ONE.
  - Accept only: skid <= D, go to TWO.
  - Release only: go to EMPTY.
  - Neither: hold.
- TWO: in_ready=0, so there is no accept. On release, main <= skid and go to ONE. Otherwise hold.
- in_ready next = (next state != TWO).
- Flush has priority over every other event:
  - next state is EMPTY, Q <= FLUSH_VAL, out_valid <= 0, in_ready <= 1;
  - a same-cycle accept is dropped;
  - a same-cycle release still completes downstream.
- Payload is never modified, reordered, duplicated or dropped, except on flush.

## Timing
- Reset values:
  - state EMPTY, out_valid 0, in_ready 0, Q = FLUSH_VAL, skid = 0, stall_cnt 0.
  - in_ready rises on the first edge after RESET returns to 1.
- Reset mid-operation: all held entries are discarded at that edge, with no release.
- Latency: one cycle from accept to out_valid. Throughput: one transfer per cycle while out_ready=1.
- in_ready falls on the edge after the second entry is captured. There is no combinational path from out_ready to in_ready.
- Q and out_valid are stable while out_valid=1 and out_ready=0.

## Configuration
- PIPE_REG_STALL_CNT_EN defined:
  - stall_cnt port exists.
  - Increments each cycle out_valid=1 and out_ready=0, saturating at 16'hFFFF.
  - Cleared by reset and by flush.
- Not defined: the port and counter are absent, and all other behaviour is identical.

## Structure
- Shared package pipe_pkg holds:
  - the state typedef (PS_EMPTY, PS_ONE, PS_TWO);
  - the stall counter width constant (16);
  - the saturation value.
- Sub-module ld_reg: a parametrised WIDTH load-enable register with synchronous active-low reset and a reset-value parameter. Instantiate it twice, for main and skid.
- The FSM and handshake logic live in pipe_stage_reg.

## Test plan
- Reset, streaming: RESET=0 for 2 cycles, then 1; in_valid=1 with D=1,2,3,4 on consecutive cycles; out_ready=1 -> in_ready=1 one cycle after release; Q=1,2,3,4 on out_valid cycles, each one cycle after its accept.
- Backpressure: out_ready=0; send 0xA then 0xB -> in_ready=0 after 0xB, Q=0xA held. Raise out_ready -> 0xA then 0xB delivered; in_ready returns to 1.
- Flush: state TWO holding 0x11 and 0x22; flush=1 with in_valid=1, D=0x33 -> out_valid=0, Q=FLUSH_VAL, 0x33 dropped, in_ready=1 next cycle.
- Reset mid-stream: state TWO; RESET=0 for one cycle -> out_valid=0, in_ready=0, Q=FLUSH_VAL; no stale data appears afterwards.
- WIDTH=8, FLUSH_VAL=8'hFF: reset -> Q=8'hFF; send 8'h5A -> Q=8'h5A.
- PIPE_REG_STALL_CNT_EN defined: hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF; flush -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } ps_state_t;

  localparam int STALL_CNT_W = 16;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/pipe_stage_reg_ld_reg.sv
// Load-enable register with synchronous active-low reset to a parameterised value.
module ld_reg #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready stage register with 2-entry skid: 1-cycle latency, registered in_ready, flush squashes.
// Optional stall counter (out_valid & ~out_ready cycles) enabled by PIPE_REG_STALL_CNT_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       D,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       Q
`ifdef PIPE_REG_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  ps_state_t        state;
  ps_state_t        next_state;
  logic             acc;
  logic             rel;
  logic             main_en;
  logic [WIDTH-1:0] main_d;
  logic             skid_en;
  logic [WIDTH-1:0] skid_q;

  assign acc = in_valid & in_ready;
  assign rel = out_valid & out_ready;

  // Flush wins over everything; a same-cycle release has already been seen downstream.
  always_comb begin
    next_state = state;
    main_en    = 1'b0;
    main_d     = D;
    skid_en    = 1'b0;
    if (flush) begin
      next_state = PS_EMPTY;
      main_en    = 1'b1;
      main_d     = FLUSH_VAL;
    end else begin
      case (state)
        PS_EMPTY: begin
          if (acc) begin
            main_en    = 1'b1;
            next_state = PS_ONE;
          end
        end
        PS_ONE: begin
          if (acc && rel) begin
            main_en = 1'b1;
          end else if (acc) begin
            skid_en    = 1'b1;
            next_state = PS_TWO;
          end else if (rel) begin
            next_state = PS_EMPTY;
          end
        end
        PS_TWO: begin
          if (rel) begin
            main_en    = 1'b1;
            main_d     = skid_q;
            next_state = PS_ONE;
          end
        end
        default: next_state = PS_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= PS_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state     <= next_state;
      out_valid <= (next_state != PS_EMPTY);
      in_ready  <= (next_state != PS_TWO);
    end
  end

  ld_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL (FLUSH_VAL)
  ) u_main (
    .clk   (CLK),
    .rst_n (RESET),
    .en    (main_en),
    .d     (main_d),
    .q     (Q)
  );

  ld_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL ('0)
  ) u_skid (
    .clk   (CLK),
    .rst_n (RESET),
    .en    (skid_en),
    .d     (D),
    .q     (skid_q)
  );

`ifdef PIPE_REG_STALL_CNT_EN
  always_ff @(posedge CLK) begin
    if (!RESET || flush) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != STALL_CNT_MAX)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus randomized traffic against a queue model.
module tb_pipe_stage_reg;

  logic        CLK;
  logic        RESET;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic [31:0] D;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] Q;
  logic        in_ready8;
  logic        out_valid8;
  logic [7:0]  Q8;
`ifdef PIPE_REG_STALL_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] stall_cnt8;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the entries held by the stage, oldest first.
  logic [31:0] mq[$];
  logic        m_rdy   = 1'b0;
  logic [31:0] m_last  = 32'h0;
  logic [7:0]  m_last8 = 8'hFF;
  int          m_stall = 0;

  pipe_stage_reg #(.WIDTH(32), .FLUSH_VAL(32'h0)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .D         (D),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (Q)
`ifdef PIPE_REG_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  pipe_stage_reg #(.WIDTH(8), .FLUSH_VAL(8'hFF)) dut8 (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_valid  (in_valid),
    .in_ready  (in_ready8),
    .D         (D[7:0]),
    .flush     (flush),
    .out_valid (out_valid8),
    .out_ready (out_ready),
    .Q         (Q8)
`ifdef PIPE_REG_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt8)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One clock: advance the model on the rising edge, return at the falling edge.
  task automatic step();
    logic acc_m;
    logic rel_m;
    @(posedge CLK);
    if (!RESET) begin
      mq.delete();
      m_rdy   = 1'b0;
      m_last  = 32'h0;
      m_last8 = 8'hFF;
      m_stall = 0;
    end else begin
      acc_m = in_valid && m_rdy;
      rel_m = (mq.size() > 0) && out_ready;
      if ((mq.size() > 0) && !out_ready && (m_stall < 65535)) m_stall++;
      if (rel_m) void'(mq.pop_front());
      if (flush) begin
        mq.delete();
        m_last  = 32'h0;
        m_last8 = 8'hFF;
        m_stall = 0;
      end else if (acc_m) begin
        mq.push_back(D);
      end
      m_rdy = (mq.size() < 2);
      if (mq.size() > 0) begin
        m_last  = mq[0];
        m_last8 = mq[0][7:0];
      end
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; D = 32'h0;
    step(); step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
    n_cmp++; if (Q !== 32'h0) begin n_bad++; $display("FAIL reset_q got %h want 00000000", Q); end
    n_cmp++; if (Q8 !== 8'hFF) begin n_bad++; $display("FAIL reset_q8 got %h want ff", Q8); end
    RESET = 1'b1;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_in_ready got %0b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_release_out_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      D = 32'(k);
      step();
      n_cmp++; if (out_valid !== 1'b1 || Q !== 32'(k)) begin n_bad++; $display("FAIL stream_q[%0d] got v=%0b q=%h want v=1 q=%h", k, out_valid, Q, 32'(k)); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready[%0d] got %0b want 1", k, in_ready); end
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0 || Q !== 32'd4) begin n_bad++; $display("FAIL stream_drain got v=%0b q=%h want v=0 q=4", out_valid, Q); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; D = 32'hA;
    step();
    n_cmp++; if (out_valid !== 1'b1 || Q !== 32'hA || in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_first got v=%0b q=%h r=%0b want v=1 q=a r=1", out_valid, Q, in_ready); end
    D = 32'hB;
    step();
    n_cmp++; if (in_ready !== 1'b0 || Q !== 32'hA) begin n_bad++; $display("FAIL bp_full got r=%0b q=%h want r=0 q=a", in_ready, Q); end
    in_valid = 1'b0; D = 32'hC;
    step(); step();
    n_cmp++; if (out_valid !== 1'b1 || Q !== 32'hA || in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold got v=%0b q=%h r=%0b want v=1 q=a r=0", out_valid, Q, in_ready); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b1 || Q !== 32'hB || in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_second got v=%0b q=%h r=%0b want v=1 q=b r=1", out_valid, Q, in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty got v=%0b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    D = 32'h11; step();
    D = 32'h22; step();
    flush = 1'b1; D = 32'h33; step();
    n_cmp++; if (out_valid !== 1'b0 || Q !== 32'h0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_two got v=%0b q=%h r=%0b want v=0 q=0 r=1", out_valid, Q, in_ready); end
    n_cmp++; if (Q8 !== 8'hFF || out_valid8 !== 1'b0) begin n_bad++; $display("FAIL flush_two_q8 got v=%0b q=%h want v=0 q=ff", out_valid8, Q8); end
    // Flush while a real accept is possible: the new entry must be dropped.
    flush = 1'b0; D = 32'h44; step();
    flush = 1'b1; D = 32'h55; step();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || Q !== 32'h0) begin n_bad++; $display("FAIL flush_one got v=%0b q=%h want v=0 q=0", out_valid, Q); end
    out_ready = 1'b1; step();
    n_cmp++; if (out_valid !== 1'b0 || Q !== 32'h0) begin n_bad++; $display("FAIL flush_drop got v=%0b q=%h want v=0 q=0", out_valid, Q); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1;
    D = 32'h66; step();
    D = 32'h77; step();
    RESET = 1'b0; in_valid = 1'b0; step();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || Q !== 32'h0) begin n_bad++; $display("FAIL rstmid got v=%0b r=%0b q=%h want v=0 r=0 q=0", out_valid, in_ready, Q); end
    RESET = 1'b1; out_ready = 1'b1; step();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_after got r=%0b v=%0b want r=1 v=0", in_ready, out_valid); end
    step();
    n_cmp++; if (out_valid !== 1'b0 || Q !== 32'h0) begin n_bad++; $display("FAIL rstmid_stale got v=%0b q=%h want v=0 q=0", out_valid, Q); end
  endtask

  task automatic test_width8();
    out_ready = 1'b1; in_valid = 1'b1; D = 32'h0000_015A;
    step();
    in_valid = 1'b0;
    n_cmp++; if (Q8 !== 8'h5A || out_valid8 !== 1'b1) begin n_bad++; $display("FAIL w8_q got v=%0b q=%h want v=1 q=5a", out_valid8, Q8); end
    n_cmp++; if (Q !== 32'h0000_015A) begin n_bad++; $display("FAIL w8_q32 got %h want 0000015a", Q); end
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      RESET     = ($urandom_range(0, 63) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      D         = $urandom;
      step();
      n_cmp++; if (out_valid !== (mq.size() > 0)) begin n_bad++; $display("FAIL rnd_out_valid[%0d] got %0b want %0b", i, out_valid, (mq.size() > 0)); end
      n_cmp++; if (in_ready !== m_rdy) begin n_bad++; $display("FAIL rnd_in_ready[%0d] got %0b want %0b", i, in_ready, m_rdy); end
      n_cmp++; if (Q !== m_last) begin n_bad++; $display("FAIL rnd_q[%0d] got %h want %h", i, Q, m_last); end
      n_cmp++; if (Q8 !== m_last8) begin n_bad++; $display("FAIL rnd_q8[%0d] got %h want %h", i, Q8, m_last8); end
`ifdef PIPE_REG_STALL_CNT_EN
      n_cmp++; if (stall_cnt !== 16'(m_stall)) begin n_bad++; $display("FAIL rnd_stall[%0d] got %0d want %0d", i, stall_cnt, m_stall); end
`endif
    end
    RESET = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); step();
  endtask

`ifdef PIPE_REG_STALL_CNT_EN
  task automatic test_stall_cnt();
    flush = 1'b1; step();
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1; D = 32'h9;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 100; i++) step();
    n_cmp++; if (stall_cnt !== 16'd100) begin n_bad++; $display("FAIL stall_100 got %0d want 100", stall_cnt); end
    for (int i = 100; i < 70000; i++) step();
    n_cmp++; if (stall_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL stall_sat got %h want ffff", stall_cnt); end
    flush = 1'b1; step();
    flush = 1'b0;
    n_cmp++; if (stall_cnt !== 16'h0) begin n_bad++; $display("FAIL stall_flush got %h want 0000", stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_width8();
    test_random();
`ifdef PIPE_REG_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
